// File: rtl/dcache_pkg.sv
// Shared types and helpers for the set-associative data cache.
package dcache_pkg;

  // Controller states: serve hits, write back a dirty victim, refill a line.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Byte-lane enables of a store, from access size and the low address bits.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] m;
    case (size)
      SIZE_BYTE: m = 4'b0001 << a;
      SIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU: victim lookup and access update for one set.
// Node n has children 2n+1 (left) and 2n+2 (right); a node bit of 1 sends the
// victim search right, 0 sends it left.
module plru_tree #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         nodes_i,
  input  logic [$clog2(WAYS)-1:0] way_i,
  output logic [$clog2(WAYS)-1:0] victim_o,
  output logic [WAYS-2:0]         nodes_o
);

  localparam int LVL = $clog2(WAYS);

  // Follow the node bits from the root; the path taken spells the victim way.
  always_comb begin
    int n;
    victim_o = '0;
    n = 0;
    for (int l = 0; l < LVL; l++) begin
      victim_o[LVL-1-l] = nodes_i[n];
      n = nodes_i[n] ? (2 * n + 2) : (2 * n + 1);
    end
  end

  // Every node on the path to the accessed way is pointed away from it.
  always_comb begin
    int n;
    nodes_o = nodes_i;
    n = 0;
    for (int l = 0; l < LVL; l++) begin
      nodes_o[n] = ~way_i[LVL-1-l];
      n = way_i[LVL-1-l] ? (2 * n + 2) : (2 * n + 1);
    end
  end

endmodule

// File: rtl/d_cache_sa.sv
// Set-associative write-back, write-allocate data cache with multi-word lines.
// Misses write back a dirty victim and refill the line word by word over the
// bridge; the core's held request then completes as an ordinary hit.
//
// Handshakes: the core holds its request until cpu_data_addr_ok, which is only
// given on a hit in IDLE together with cpu_data_data_ok. On the bridge side at
// most one word is outstanding: cache_data_req is high while no address is
// pending, addr_ok with req marks the word pending, data_ok completes it.
module d_cache_sa import dcache_pkg::*; #(
  parameter int WAYS         = 4,
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
);

  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int LW        = 1 << (OFFSET_WIDTH - 2);
  localparam int WW        = $clog2(WAYS);
  localparam int KW        = (OFFSET_WIDTH > 2) ? (OFFSET_WIDTH - 2) : 1;
  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam logic [KW-1:0] K_LAST = KW'(LW - 1);

  // Per-set state; tag and data arrays carry no reset.
  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-1:0]      dirty_q [SETS];
  logic [WAYS-2:0]      plru_q  [SETS];
  logic [TAG_WIDTH-1:0] tag_q   [SETS][WAYS];
  logic [31:0]          data_q  [SETS][WAYS][LW];

  state_e               state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [TAG_WIDTH-1:0] ltag_q;
  logic [TAG_WIDTH-1:0] vtag_q;
  logic [WW-1:0]        vict_q;
  logic [KW-1:0]        k_q;
  logic                 pend_q;

  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] req_idx;
  logic [KW-1:0]          req_word;
  logic                   hit, any_inv, victim_dirty;
  logic [WW-1:0]          hit_way, inv_way, plru_victim, vict_sel, plru_way;
  logic [INDEX_WIDTH-1:0] plru_idx;
  logic [WAYS-2:0]        plru_cur, plru_upd;
  logic                   hit_take, miss_take, beat_done, last_beat;
  logic [3:0]             st_mask;
  logic [31:0]            wb_addr, fill_addr;

  assign req_tag = cpu_data_addr[31 -: TAG_WIDTH];
  assign req_idx = cpu_data_addr[OFFSET_WIDTH +: INDEX_WIDTH];

  generate
    if (OFFSET_WIDTH > 2) begin : g_word
      assign req_word = cpu_data_addr[2 +: KW];
    end else begin : g_noword
      assign req_word = '0;
    end
  endgenerate

  // Tag compare across the addressed set; at most one way can match.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  // Lowest-numbered invalid way (scanned downward so the lowest wins).
  always_comb begin
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        any_inv = 1'b1;
        inv_way = WW'(w);
      end
    end
  end

  // One PLRU tree serves the request set in IDLE and the latched set in FILL.
  assign plru_idx = (state_q == IDLE) ? req_idx : idx_q;
  assign plru_way = (state_q == FILL) ? vict_q : hit_way;
  assign plru_cur = plru_q[plru_idx];

  plru_tree #(.WAYS(WAYS)) u_plru (
    .nodes_i  (plru_cur),
    .way_i    (plru_way),
    .victim_o (plru_victim),
    .nodes_o  (plru_upd)
  );

  assign vict_sel     = any_inv ? inv_way : plru_victim;
  assign victim_dirty = valid_q[req_idx][vict_sel] & dirty_q[req_idx][vict_sel];

  assign hit_take  = (state_q == IDLE) & cpu_data_req & hit;
  assign miss_take = (state_q == IDLE) & cpu_data_req & ~hit;
  assign beat_done = pend_q & cache_data_data_ok;
  assign last_beat = beat_done & (k_q == K_LAST);
  assign st_mask   = byte_mask(cpu_data_size, cpu_data_addr[1:0]);

  assign wb_addr   = {vtag_q, idx_q, {OFFSET_WIDTH{1'b0}}} | (32'(k_q) << 2);
  assign fill_addr = {ltag_q, idx_q, {OFFSET_WIDTH{1'b0}}} | (32'(k_q) << 2);

  assign cpu_data_rdata   = data_q[req_idx][hit_way][req_word];
  assign cache_data_wdata = data_q[idx_q][vict_q][k_q];
  assign cache_data_size  = SIZE_WORD;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d          = state_q;
    cpu_data_addr_ok = 1'b0;
    cpu_data_data_ok = 1'b0;
    cache_data_req   = 1'b0;
    cache_data_wr    = 1'b0;
    cache_data_addr  = '0;
    case (state_q)
      IDLE: begin
        if (cpu_data_req) begin
          if (hit) begin
            cpu_data_addr_ok = 1'b1;
            cpu_data_data_ok = 1'b1;
          end else begin
            state_d = victim_dirty ? WB : FILL;
          end
        end
      end
      WB: begin
        cache_data_req  = ~pend_q;
        cache_data_wr   = 1'b1;
        cache_data_addr = wb_addr;
        if (last_beat) state_d = FILL;
      end
      FILL: begin
        cache_data_req  = ~pend_q;
        cache_data_addr = fill_addr;
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Miss latches, bridge bookkeeping and per-set valid/dirty/PLRU bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 1'b0;
      k_q    <= '0;
      idx_q  <= '0;
      ltag_q <= '0;
      vtag_q <= '0;
      vict_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (miss_take) begin
        idx_q  <= req_idx;
        ltag_q <= req_tag;
        vtag_q <= tag_q[req_idx][vict_sel];
        vict_q <= vict_sel;
      end
      if (cache_data_req && cache_data_addr_ok) pend_q <= 1'b1;
      if (beat_done) begin
        pend_q <= 1'b0;
        k_q    <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
      end
      if (hit_take) begin
        plru_q[req_idx] <= plru_upd;
        if (cpu_data_wr) dirty_q[req_idx][hit_way] <= 1'b1;
      end
      if ((state_q == FILL) && last_beat) begin
        valid_q[idx_q][vict_q] <= 1'b1;
        dirty_q[idx_q][vict_q] <= 1'b0;
        plru_q[idx_q]          <= plru_upd;
      end
    end
  end

  // Tag/data arrays: refill words, install the tag, merge store hits.
  always_ff @(posedge clk) begin
    if ((state_q == FILL) && beat_done) data_q[idx_q][vict_q][k_q] <= cache_data_rdata;
    if ((state_q == FILL) && last_beat) tag_q[idx_q][vict_q] <= ltag_q;
    if (hit_take && cpu_data_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (st_mask[b]) data_q[req_idx][hit_way][req_word][8*b +: 8] <= cpu_data_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_d_cache_sa.sv
// Bench for d_cache_sa: directed core accesses, a bridge/memory model with
// programmable handshake delays, and a scoreboard checking load data and the
// exact sequence of bridge transactions.
module tb_d_cache_sa;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_data_req, cpu_data_wr;
  logic [1:0]  cpu_data_size;
  logic [31:0] cpu_data_addr, cpu_data_wdata, cpu_data_rdata;
  logic        cpu_data_addr_ok, cpu_data_data_ok;
  logic        cache_data_req, cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr, cache_data_wdata, cache_data_rdata;
  logic        cache_data_addr_ok, cache_data_data_ok;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];   // {is_store, load data}
  logic [64:0] bexp_q[$];  // {wr, addr, wdata}
  logic [31:0] mem [logic [31:0]];

  int addr_dly = 1;
  int data_dly = 1;
  int b_words  = 0;
  int req_viol = 0;

  d_cache_sa dut (
    .clk                (clk),
    .rst                (rst),
    .cpu_data_req       (cpu_data_req),
    .cpu_data_wr        (cpu_data_wr),
    .cpu_data_size      (cpu_data_size),
    .cpu_data_addr      (cpu_data_addr),
    .cpu_data_wdata     (cpu_data_wdata),
    .cpu_data_rdata     (cpu_data_rdata),
    .cpu_data_addr_ok   (cpu_data_addr_ok),
    .cpu_data_data_ok   (cpu_data_data_ok),
    .cache_data_req     (cache_data_req),
    .cache_data_wr      (cache_data_wr),
    .cache_data_size    (cache_data_size),
    .cache_data_addr    (cache_data_addr),
    .cache_data_wdata   (cache_data_wdata),
    .cache_data_rdata   (cache_data_rdata),
    .cache_data_addr_ok (cache_data_addr_ok),
    .cache_data_data_ok (cache_data_data_ok)
  );

  // Clock.
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_addr_ok"}, {31'b0, cpu_data_addr_ok}, 32'd0);
    chk({tag, "_data_ok"}, {31'b0, cpu_data_data_ok}, 32'd0);
    chk({tag, "_bridge_req"}, {31'b0, cache_data_req}, 32'd0);
    chk({tag, "_bridge_wr"}, {31'b0, cache_data_wr}, 32'd0);
    chk({tag, "_bridge_size"}, {30'b0, cache_data_size}, 32'd2);
    chk({tag, "_bridge_addr"}, cache_data_addr, 32'd0);
  endtask

  task automatic push_fill(input logic [31:0] base);
    for (int k = 0; k < 4; k++) bexp_q.push_back({1'b0, base + 32'(4 * k), 32'h0});
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    bexp_q.push_back({1'b1, a, d});
  endtask

  // Drive one core access; exp_lat < 0 skips the wait-cycle check.
  task automatic cpu_access(input string name, input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rd, input int exp_lat);
    int  lat;
    bit  done;
    @(posedge clk); #1;
    cpu_data_req   = 1'b1;
    cpu_data_wr    = wr;
    cpu_data_size  = size;
    cpu_data_addr  = addr;
    cpu_data_wdata = wdata;
    exp_q.push_back({wr, wr ? 32'h0 : exp_rd});
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 2000) begin
      @(negedge clk);
      if (cpu_data_addr_ok) done = 1'b1;
      else lat++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_handshake got=timeout expected=addr_ok", name);
    end else if (exp_lat >= 0) begin
      chk({name, "_wait_cycles"}, 32'(lat), 32'(exp_lat));
    end
    @(posedge clk); #1;
    cpu_data_req = 1'b0;
    cpu_data_wr  = 1'b0;
  endtask

  // Bridge and memory model: one word at a time with programmable delays.
  initial begin : bridge
    int          phase, cnt;
    logic [31:0] a, d;
    logic        w;
    logic [64:0] e;
    cache_data_addr_ok = 1'b0;
    cache_data_data_ok = 1'b0;
    cache_data_rdata   = '0;
    phase = 0;
    cnt   = 0;
    a = '0; d = '0; w = 1'b0;
    forever begin
      @(negedge clk);
      cache_data_addr_ok = 1'b0;
      cache_data_data_ok = 1'b0;
      if (rst !== 1'b1) begin
        phase = 0;
        cnt   = 0;
      end else if (phase == 0) begin
        if (cache_data_req) begin
          if (cnt >= addr_dly - 1) begin
            cache_data_addr_ok = 1'b1;
            a = cache_data_addr;
            w = cache_data_wr;
            d = cache_data_wdata;
            phase = 1;
            cnt   = 0;
            checks++;
            if (bexp_q.size() == 0) begin
              errors++;
              $display("FAIL bridge_txn got wr=%0d addr=%h expected=none", w, a);
            end else begin
              e = bexp_q.pop_front();
              if (e[64] !== w || e[63:32] !== a || (w && e[31:0] !== d)) begin
                errors++;
                $display("FAIL bridge_txn got wr=%0d addr=%h wdata=%h expected wr=%0d addr=%h wdata=%h",
                         w, a, d, e[64], e[63:32], e[31:0]);
              end
            end
          end else begin
            cnt++;
          end
        end
      end else begin
        if (cache_data_req) req_viol++;
        if (cnt >= data_dly - 1) begin
          cache_data_data_ok = 1'b1;
          if (w) mem[a] = d;
          else   cache_data_rdata = mem_rd(a);
          b_words++;
          phase = 0;
          cnt   = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: every returned response is matched against the expected queue.
  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && cpu_data_data_ok) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cpu_response got=data_ok expected=none");
        end else begin
          e = exp_q.pop_front();
          if (!e[32]) chk("load_data", cpu_data_rdata, e[31:0]);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    bit done;
    rst            = 1'b0;
    cpu_data_req   = 1'b0;
    cpu_data_wr    = 1'b0;
    cpu_data_size  = 2'b10;
    cpu_data_addr  = '0;
    cpu_data_wdata = '0;
    mem[32'h0000_1004] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    rst = 1'b1;

    // Cold miss, then hits on the filled line.
    push_fill(32'h1000);
    cpu_access("ld_1000_miss", 1'b0, 2'b10, 32'h1000, 32'h0, 32'hC0DE_1000, 9);
    cpu_access("ld_1004_hit",  1'b0, 2'b10, 32'h1004, 32'h0, 32'hDEAD_BEEF, 0);
    cpu_access("sb_1001",      1'b1, 2'b00, 32'h1001, 32'h0000_AB00, 32'h0, 0);
    cpu_access("ld_1000_merge", 1'b0, 2'b10, 32'h1000, 32'h0, 32'hC0DE_AB00, 0);

    // Fill the remaining ways of set 0.
    push_fill(32'h0000);
    cpu_access("ld_0000_miss", 1'b0, 2'b10, 32'h0000, 32'h0, 32'hC0DE_0000, 9);
    push_fill(32'h0800);
    cpu_access("ld_0808_miss", 1'b0, 2'b10, 32'h0808, 32'h0, 32'hC0DE_0808, 9);
    push_fill(32'h1800);
    cpu_access("ld_180c_miss", 1'b0, 2'b10, 32'h180C, 32'h0, 32'hC0DE_180C, 9);

    // Touch ways 0,1,2,3,0: tree PLRU victim is way 2 (line 0x0800).
    cpu_access("hit_w0", 1'b0, 2'b10, 32'h1000, 32'h0, 32'hC0DE_AB00, 0);
    cpu_access("hit_w1", 1'b0, 2'b10, 32'h0000, 32'h0, 32'hC0DE_0000, 0);
    cpu_access("hit_w2", 1'b0, 2'b10, 32'h0800, 32'h0, 32'hC0DE_0800, 0);
    cpu_access("hit_w3", 1'b0, 2'b10, 32'h1800, 32'h0, 32'hC0DE_1800, 0);
    cpu_access("hit_w0b", 1'b0, 2'b10, 32'h1000, 32'h0, 32'hC0DE_AB00, 0);
    push_fill(32'h2000);
    cpu_access("ld_2004_evict_w2", 1'b0, 2'b10, 32'h2004, 32'h0, 32'hC0DE_2004, 9);

    // Remaining lines still hit; order leaves dirty way 0 as the victim.
    cpu_access("hit_1800", 1'b0, 2'b10, 32'h1800, 32'h0, 32'hC0DE_1800, 0);
    cpu_access("hit_0000", 1'b0, 2'b10, 32'h0000, 32'h0, 32'hC0DE_0000, 0);
    cpu_access("hit_2000", 1'b0, 2'b10, 32'h2000, 32'h0, 32'hC0DE_2000, 0);

    // Dirty eviction: four write-backs precede four reads.
    push_wr(32'h1000, 32'hC0DE_AB00);
    push_wr(32'h1004, 32'hDEAD_BEEF);
    push_wr(32'h1008, 32'hC0DE_1008);
    push_wr(32'h100C, 32'hC0DE_100C);
    push_fill(32'h2800);
    cpu_access("ld_2800_dirty_miss", 1'b0, 2'b10, 32'h2800, 32'h0, 32'hC0DE_2800, 17);

    // Written-back line comes back from memory with the merged byte.
    push_fill(32'h1000);
    cpu_access("ld_1000_refetch", 1'b0, 2'b10, 32'h1000, 32'h0, 32'hC0DE_AB00, 9);

    // Store miss allocates, then merges on the retried hit.
    push_fill(32'h3000);
    cpu_access("sw_3004_miss", 1'b1, 2'b10, 32'h3004, 32'h1234_5678, 32'h0, 9);
    cpu_access("ld_3004", 1'b0, 2'b10, 32'h3004, 32'h0, 32'h1234_5678, 0);
    cpu_access("sh_3006", 1'b1, 2'b01, 32'h3006, 32'hBEEF_0000, 32'h0, 0);
    cpu_access("ld_3004_half", 1'b0, 2'b10, 32'h3004, 32'h0, 32'hBEEF_5678, 0);

    // Reset during the third fill word.
    b_words = 0;
    bexp_q.push_back({1'b0, 32'h4000, 32'h0});
    bexp_q.push_back({1'b0, 32'h4004, 32'h0});
    @(posedge clk); #1;
    cpu_data_req  = 1'b1;
    cpu_data_wr   = 1'b0;
    cpu_data_size = 2'b10;
    cpu_data_addr = 32'h4000;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (b_words >= 2) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL fill_progress got=%0d words expected=2", b_words);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_reset("mid_fill");
    chk("fill_txns_before_reset", 32'(bexp_q.size()), 32'd0);
    cpu_data_req = 1'b0;
    bexp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Everything was invalidated; the dirty 0x3000 line is lost without write-back.
    push_fill(32'h4000);
    cpu_access("ld_4000_after_rst", 1'b0, 2'b10, 32'h4000, 32'h0, 32'hC0DE_4000, 9);
    push_fill(32'h1000);
    cpu_access("ld_1004_after_rst", 1'b0, 2'b10, 32'h1004, 32'h0, 32'hDEAD_BEEF, 9);
    push_fill(32'h3000);
    cpu_access("ld_3004_after_rst", 1'b0, 2'b10, 32'h3004, 32'h0, 32'hC0DE_3004, 9);

    // Slow bridge: addr_ok after 3 cycles, data_ok after 5.
    addr_dly = 3;
    data_dly = 5;
    req_viol = 0;
    push_fill(32'h5000);
    cpu_access("ld_5008_slow", 1'b0, 2'b10, 32'h5008, 32'h0, 32'hC0DE_5008, -1);
    chk("req_while_pending", 32'(req_viol), 32'd0);
    chk("slow_bridge_txns_left", 32'(bexp_q.size()), 32'd0);
    addr_dly = 1;
    data_dly = 1;

    repeat (4) @(posedge clk);
    chk("cpu_responses_left", 32'(exp_q.size()), 32'd0);
    chk("bridge_txns_left", 32'(bexp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
